// File: rtl/keypad_pkg.sv
// Shared types, defaults and key decoding for the 4x4 hex keypad scan controller.
package keypad_pkg;

  localparam int unsigned SCAN_CYCLES_DEF     = 4800;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1200;

  typedef logic [3:0] hex_t;

  typedef enum logic [2:0] {
    SCAN,
    DEBOUNCE,
    CHECK,
    EMIT,
    HOLD,
    RELEASE_WAIT
  } scan_state_t;

  // Keypad legend, row-major: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic hex_t key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    hex_t k;
    case ({row_idx, col_idx})
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'hE;
      4'd13: k = 4'h0;
      4'd14: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Index of the set bit of a one-hot row vector (callers guarantee one-hot).
  function automatic logic [1:0] onehot_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix and decoded-key signals between the scan controller and its neighbours.
interface keypad_scan_ctrl_if;
  import keypad_pkg::*;

  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic       key_valid;
  hex_t       key_hex;
  hex_t       digit_l;
  hex_t       digit_r;
  logic       key_held;

  modport master (
    input  rows_n,
    output cols_n, key_valid, key_hex, digit_l, digit_r, key_held
  );

  modport slave (
    output rows_n,
    input  cols_n, key_valid, key_hex, digit_l, digit_r, key_held
  );

endinterface

// File: rtl/debounce_timer.sv
// Clearable saturating up-counter; done_c flags the final cycle of a TERMINAL-cycle interval.
module debounce_timer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TERMINAL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                count <= '0;
    else if (clr)              count <= '0;
    else if (en && !done_c)    count <= count + WIDTH'(1);
  end

  assign done_c = (count == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scanner with press debounce/validation, one pulse per press and a two-digit history.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = SCAN_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  keypad_scan_ctrl_if.master  kp
);

  localparam int unsigned MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  scan_state_t state, state_d;
  logic [1:0]  col, col_d;
  logic [3:0]  row_cap, row_cap_d;
  logic [3:0]  sync1, sync2;
  logic [3:0]  rows_c;
  logic [3:0]  cols_n_q, cols_n_d;
  logic        key_valid_q, key_valid_d;
  hex_t        key_hex_q, key_hex_d;
  hex_t        digit_l_q, digit_l_d;
  hex_t        digit_r_q, digit_r_d;
  logic        key_held_q, key_held_d;
  logic        dwell_clr_c, dwell_en_c, dwell_done_c;
  logic        deb_clr_c, deb_en_c, deb_done_c;

  // Two-flop synchronizer, idles at "no row pulled low"
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= kp.rows_n;
      sync2 <= sync1;
    end
  end

  assign rows_c = ~sync2;

  assign dwell_en_c  = (state == SCAN);
  assign dwell_clr_c = (state != SCAN) || dwell_done_c;
  assign deb_en_c    = (state == DEBOUNCE) || ((state == RELEASE_WAIT) && (rows_c == 4'h0));
  assign deb_clr_c   = !((state == DEBOUNCE) || (state == RELEASE_WAIT));

  debounce_timer #(.WIDTH(CNT_W), .TERMINAL(SCAN_CYCLES)) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (dwell_clr_c),
    .en     (dwell_en_c),
    .done_c (dwell_done_c)
  );

  debounce_timer #(.WIDTH(CNT_W), .TERMINAL(DEBOUNCE_CYCLES)) u_deb_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (deb_clr_c),
    .en     (deb_en_c),
    .done_c (deb_done_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      col         <= 2'd0;
      row_cap     <= 4'h0;
      cols_n_q    <= 4'b1110;
      key_valid_q <= 1'b0;
      key_hex_q   <= 4'h0;
      digit_l_q   <= 4'h0;
      digit_r_q   <= 4'h0;
      key_held_q  <= 1'b0;
    end else begin
      state       <= state_d;
      col         <= col_d;
      row_cap     <= row_cap_d;
      cols_n_q    <= cols_n_d;
      key_valid_q <= key_valid_d;
      key_hex_q   <= key_hex_d;
      digit_l_q   <= digit_l_d;
      digit_r_q   <= digit_r_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next state; registered outputs are derived from the next state so they line up with it
  always_comb begin
    state_d     = state;
    col_d       = col;
    row_cap_d   = row_cap;
    key_valid_d = 1'b0;
    key_hex_d   = key_hex_q;
    digit_l_d   = digit_l_q;
    digit_r_d   = digit_r_q;

    case (state)
      SCAN: begin
        if (dwell_done_c) begin
          if (rows_c != 4'h0) begin
            row_cap_d = rows_c;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (deb_done_c) state_d = CHECK;
      end
      CHECK: begin
        if ((rows_c == row_cap) && $onehot(row_cap)) begin
          state_d     = EMIT;
          key_valid_d = 1'b1;
          key_hex_d   = key_map(onehot_index(row_cap), col);
          digit_l_d   = digit_r_q;
          digit_r_d   = key_hex_d;
        end else begin
          col_d   = col + 2'd1;
          state_d = SCAN;
        end
      end
      EMIT: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (rows_c == 4'h0) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (rows_c != 4'h0) begin
          state_d = HOLD;
        end else if (deb_done_c) begin
          col_d   = col + 2'd1;
          state_d = SCAN;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    cols_n_d   = ~(4'b0001 << col_d);
    key_held_d = (state_d == HOLD) || (state_d == RELEASE_WAIT);
  end

  assign kp.cols_n    = cols_n_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_hex   = key_hex_q;
  assign kp.digit_l   = digit_l_q;
  assign kp.digit_r   = digit_r_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: physical keypad model, cycle reference model and directed/random presses.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  localparam int P_SCAN = 0, P_DEB = 1, P_CHK = 2, P_EMIT = 3, P_HOLD = 4, P_RW = 5;

  localparam logic [3:0] KM [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                     4'h4, 4'h5, 4'h6, 4'hB,
                                     4'h7, 4'h8, 4'h9, 4'hC,
                                     4'hE, 4'h0, 4'hF, 4'hD};

  typedef struct {
    int         phase;
    int         left;
    int         col;
    logic [3:0] cap;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] hex;
    logic [3:0] dl;
    logic [3:0] dr;
    logic       kv;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [15:0] pressed;
  logic [3:0]  glitch_n;
  bit          run_cmp = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pulse = 0;
  mdl_t        m;

  always #5 clk = ~clk;

  keypad_scan_ctrl_if ifc ();

  keypad_scan_ctrl #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (ifc)
  );

  // Physical matrix: a pressed key pulls its row low only while its column is driven
  always_comb begin
    logic [3:0] r;
    r = glitch_n;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[rr*4+cc] && !ifc.cols_n[cc]) r[rr] = 1'b0;
    ifc.rows_n = r;
  end

  function automatic mdl_t mreset();
    mdl_t n;
    n.phase = P_SCAN; n.left = SCAN; n.col = 0;
    n.cap = 4'h0; n.s1 = 4'hF; n.s2 = 4'hF;
    n.hex = 4'h0; n.dl = 4'h0; n.dr = 4'h0; n.kv = 1'b0;
    return n;
  endfunction

  function automatic int row_of(input logic [3:0] v);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // One clock of the controller's rules, with countdowns of remaining cycles per phase
  function automatic mdl_t step(input mdl_t cur, input logic [3:0] raw);
    mdl_t n = cur;
    logic [3:0] r = ~cur.s2;
    n.s2 = cur.s1;
    n.s1 = raw;
    n.kv = 1'b0;
    case (cur.phase)
      P_SCAN:
        if (cur.left == 1) begin
          if (r != 4'h0) begin n.cap = r; n.phase = P_DEB; n.left = DEB; end
          else begin n.col = (cur.col + 1) % 4; n.left = SCAN; end
        end else n.left = cur.left - 1;
      P_DEB:
        if (cur.left == 1) n.phase = P_CHK;
        else n.left = cur.left - 1;
      P_CHK:
        if (r == cur.cap && $countones(cur.cap) == 1) begin
          n.phase = P_EMIT;
          n.kv    = 1'b1;
          n.hex   = KM[row_of(cur.cap)*4 + cur.col];
          n.dl    = cur.dr;
          n.dr    = n.hex;
        end else begin
          n.col = (cur.col + 1) % 4; n.phase = P_SCAN; n.left = SCAN;
        end
      P_EMIT: n.phase = P_HOLD;
      P_HOLD:
        if (r == 4'h0) begin n.phase = P_RW; n.left = DEB; end
      default:
        if (r != 4'h0) n.phase = P_HOLD;
        else if (cur.left == 1) begin
          n.col = (cur.col + 1) % 4; n.phase = P_SCAN; n.left = SCAN;
        end else n.left = cur.left - 1;
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mreset();
    else        m <= step(m, ifc.rows_n);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [3:0] ec;
    if (run_cmp) begin
      ec = 4'hF;
      ec[m.col[1:0]] = 1'b0;
      chk("cols_n",    ifc.cols_n,    ec);
      chk("key_valid", ifc.key_valid, m.kv);
      chk("key_hex",   ifc.key_hex,   m.hex);
      chk("digit_l",   ifc.digit_l,   m.dl);
      chk("digit_r",   ifc.digit_r,   m.dr);
      chk("key_held",  ifc.key_held,  (m.phase == P_HOLD || m.phase == P_RW));
    end
  end

  always @(negedge clk) if (reset && ifc.key_valid) n_pulse++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input string nm, input int budget);
    int k = 0;
    while (!ifc.key_valid && k < budget) begin cyc(1); k++; end
    chk({nm, "_pulse_seen"}, ifc.key_valid, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (ifc.key_held && k < budget) begin cyc(1); k++; end
    chk({nm, "_released"}, ifc.key_held, 0);
  endtask

  // Full press/hold/release of one key, optionally bouncing on release
  task automatic press_key(input int r, input int c, input int hold, input bit bounce, input string nm);
    int p0 = n_pulse;
    pressed = 16'(1) << (r*4 + c);
    wait_pulse(nm, 200);
    chk({nm, "_hex"}, ifc.key_hex, KM[r*4 + c]);
    cyc(hold);
    if (bounce)
      for (int j = 0; j < 6; j++) begin
        pressed = ($urandom_range(0, 1) == 1) ? (16'(1) << (r*4 + c)) : 16'h0;
        cyc(1);
      end
    pressed = 16'h0;
    wait_idle(nm, 100);
    cyc(2);
    chk({nm, "_npulse"}, n_pulse - p0, 1);
  endtask

  initial begin
    int k, cnt, p0;
    reset    = 1'b1;
    pressed  = 16'h0;
    glitch_n = 4'hF;
    #2 reset = 1'b0;
    cyc(3);
    run_cmp = 1'b1;
    chk("rst_cols_n", ifc.cols_n, 4'hE);
    chk("rst_digit_r", ifc.digit_r, 0);

    // Idle scan: column changes every SCAN cycles, never a pulse
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [3:0] e;
      cyc(1);
      e = 4'hF;
      e[(i/4) % 4] = 1'b0;
      chk("idle_cols_n", ifc.cols_n, e);
    end
    chk("idle_npulse", n_pulse, 0);

    // Key 6 (row 1, col 2), held 40 cycles
    pressed = 16'(1) << 6;
    wait_pulse("k6", 200);
    chk("k6_hex", ifc.key_hex, 4'h6);
    chk("k6_digit_r", ifc.digit_r, 4'h6);
    chk("k6_digit_l", ifc.digit_l, 4'h0);
    cyc(40);
    chk("k6_held", ifc.key_held, 1);
    pressed = 16'h0;
    cnt = 0;
    for (int j = 0; j < 40; j++) begin cyc(1); if (!ifc.key_held) break; cnt++; end
    chk("k6_release_len", cnt, 10);
    chk("k6_npulse", n_pulse, 1);

    // Key 5 then key A
    press_key(1, 1, 12, 1'b0, "k5");
    press_key(0, 3, 5, 1'b0, "kA");
    chk("seq_digit_l", ifc.digit_l, 4'h5);
    chk("seq_digit_r", ifc.digit_r, 4'hA);

    // Short glitch on row 0 while column 0 is being sampled
    p0 = n_pulse;
    k = 0; while (ifc.cols_n == 4'hE && k < 50) begin cyc(1); k++; end
    k = 0; while (ifc.cols_n != 4'hE && k < 50) begin cyc(1); k++; end
    chk("gl_sync", ifc.cols_n, 4'hE);
    glitch_n = 4'hE;
    cyc(3);
    glitch_n = 4'hF;
    k = 0; while (ifc.cols_n == 4'hE && k < 60) begin cyc(1); k++; end
    chk("gl_next_col", ifc.cols_n, 4'hD);
    chk("gl_npulse", n_pulse - p0, 0);

    // Release bounce: released, released, pressed, pressed, then released for good
    p0 = n_pulse;
    pressed = 16'(1) << 8;
    wait_pulse("b7", 200);
    chk("b7_hex", ifc.key_hex, 4'h7);
    cyc(5);
    pressed = 16'h0; cyc(1);
    pressed = 16'h0; cyc(1);
    pressed = 16'(1) << 8; cyc(1);
    pressed = 16'(1) << 8; cyc(1);
    pressed = 16'h0;
    cnt = 0;
    for (int j = 0; j < 40; j++) begin cyc(1); if (!ifc.key_held) break; cnt++; end
    chk("b7_release_len", cnt, 10);
    chk("b7_npulse", n_pulse - p0, 1);

    // Reset in the middle of DEBOUNCE
    cyc(3);
    p0 = n_pulse;
    pressed = 16'(1) << 15;
    k = 0; while (m.phase != P_DEB && k < 100) begin cyc(1); k++; end
    chk("rd_in_debounce", m.phase, P_DEB);
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rd_cols_n", ifc.cols_n, 4'hE);
    chk("rd_key_valid", ifc.key_valid, 0);
    chk("rd_key_hex", ifc.key_hex, 0);
    chk("rd_digit_l", ifc.digit_l, 0);
    chk("rd_digit_r", ifc.digit_r, 0);
    chk("rd_key_held", ifc.key_held, 0);
    pressed = 16'h0;
    cyc(2);
    reset = 1'b1;
    cyc(40);
    chk("rd_npulse", n_pulse - p0, 0);

    // Randomized presses, glitches and multi-row presses
    for (int it = 0; it < 25; it++) begin
      int kind = $urandom_range(0, 3);
      int r = $urandom_range(0, 3);
      int c = $urandom_range(0, 3);
      if (kind <= 1) begin
        press_key(r, c, $urandom_range(0, 30), 1'(kind), "rnd_key");
      end else if (kind == 2) begin
        p0 = n_pulse;
        cyc($urandom_range(0, 15));
        glitch_n = ~(4'(1) << r);
        cyc($urandom_range(1, 6));
        glitch_n = 4'hF;
        cyc(30);
        chk("rnd_glitch_npulse", n_pulse - p0, 0);
      end else begin
        p0 = n_pulse;
        pressed = (16'(1) << (r*4 + c)) | (16'(1) << (((r+1)%4)*4 + c));
        cyc(40);
        pressed = 16'h0;
        cyc(30);
        chk("rnd_multi_npulse", n_pulse - p0, 0);
      end
      cyc($urandom_range(0, 10));
    end

    cyc(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
